// File: rtl/raw_wr_defs.sv
// Shared definitions for the raw-pixel FIFO write side: FSM encoding and
// word-format constants used by raw_fifo_writer.
package raw_wr_defs;

    typedef enum logic [2:0] {
        WAIT_FS  = 3'd0,
        IN_FRAME = 3'd1,
        LINE     = 3'd2,
        PAD      = 3'd3,
        DROP     = 3'd4
    } wr_state_t;

    localparam int RAW_W  = 8;
    localparam int WORD_W = 16;

    localparam logic [RAW_W-1:0] PAD_DEFAULT = 8'h00;

    // The HDMI reader only looks at the low byte; the upper byte is always zero.
    function automatic logic [WORD_W-1:0] pack_word(input logic [RAW_W-1:0] pix);
        return {{(WORD_W-RAW_W){1'b0}}, pix};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/raw_fifo_writer.sv
// Write side of the raw-pixel FIFO: forces every frame to exactly
// V_ACTIVE lines of H_ACTIVE words (pad short, truncate long, resync on overflow).
module raw_fifo_writer
    import raw_wr_defs::*;
#(
    parameter int               H_ACTIVE  = 1280,
    parameter int               V_ACTIVE  = 720,
    parameter logic [RAW_W-1:0] PAD_VALUE = PAD_DEFAULT,
    parameter int               CNT_W     = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pix_fs,
    input  logic              pix_fe,
    input  logic              pix_lv,
    input  logic              pix_valid,
    input  logic [RAW_W-1:0]  pix_data,
    input  logic              fifo_full,
    output logic              fifo_wr_en,
    output logic [WORD_W-1:0] fifo_wr_data,
    output logic              frame_done,
    output logic              err_sticky,
    input  logic              err_clr,
    output logic [15:0]       ovf_cnt,
    output logic [2:0]        dbg_state
);

    // Handshake: there is no back-pressure toward the pixel source. A pixel
    // is accepted on any edge where pix_lv & pix_valid; the FIFO accepts a
    // word on every edge where fifo_wr_en is high, and fifo_full must already
    // be high while at least 2 entries remain so the registered strobe is safe.

    localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_ACTIVE);

    wr_state_t        state_q, state_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0] line_cnt_q, line_cnt_d;
    logic             fe_pend_q, fe_pend_d;
    logic             skip_q, skip_d;
    logic             wr_en_d;
    logic [RAW_W-1:0] wr_byte_d;
    logic             done_d;
    logic             err_set;
    logic             ovf_evt;

    logic pix_take;
    logic pix_room;
    logic pad_last;
    logic lines_done;

    assign pix_take   = pix_lv & pix_valid;
    assign pix_room   = (pix_cnt_q < H_MAX);
    assign pad_last   = ((pix_cnt_q + CNT_W'(1)) == H_MAX);
    assign lines_done = (line_cnt_q == V_MAX);

    always_comb begin
        state_d    = state_q;
        pix_cnt_d  = pix_cnt_q;
        line_cnt_d = line_cnt_q;
        fe_pend_d  = fe_pend_q;
        skip_d     = skip_q;
        wr_en_d    = 1'b0;
        wr_byte_d  = pix_data;
        done_d     = 1'b0;
        err_set    = 1'b0;
        ovf_evt    = 1'b0;

        case (state_q)
            WAIT_FS: begin
                if (pix_fs) begin
                    state_d    = IN_FRAME;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                    fe_pend_d  = 1'b0;
                    skip_d     = 1'b0;
                end
            end

            IN_FRAME: begin
                if (pix_fe || fe_pend_q) begin
                    // Frame end is judged first; a coincident fs then reopens a frame.
                    fe_pend_d = 1'b0;
                    if (lines_done) done_d  = 1'b1;
                    else            err_set = 1'b1;
                    state_d = WAIT_FS;
                    if (pix_fs) begin
                        state_d    = IN_FRAME;
                        line_cnt_d = '0;
                        pix_cnt_d  = '0;
                    end
                end else if (pix_fs) begin
                    err_set    = 1'b1;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                end else if (pix_take) begin
                    state_d = LINE;
                    if (lines_done) begin
                        err_set   = 1'b1;
                        skip_d    = 1'b1;
                        pix_cnt_d = '0;
                    end else if (fifo_full) begin
                        ovf_evt = 1'b1;
                        err_set = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_en_d   = 1'b1;
                        pix_cnt_d = CNT_W'(1);
                        skip_d    = 1'b0;
                    end
                end
            end

            LINE: begin
                if (pix_fs) begin
                    err_set    = 1'b1;
                    state_d    = IN_FRAME;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                    fe_pend_d  = 1'b0;
                    skip_d     = 1'b0;
                end else if (!pix_lv || pix_fe) begin
                    if (pix_fe) fe_pend_d = 1'b1;
                    skip_d = 1'b0;
                    if (skip_q) begin
                        state_d   = IN_FRAME;
                        pix_cnt_d = '0;
                    end else if (pix_room) begin
                        state_d = PAD;
                        err_set = 1'b1;
                    end else begin
                        state_d    = IN_FRAME;
                        line_cnt_d = line_cnt_q + CNT_W'(1);
                        pix_cnt_d  = '0;
                    end
                end else if (pix_valid && !skip_q) begin
                    if (!pix_room) begin
                        err_set = 1'b1;
                    end else if (fifo_full) begin
                        ovf_evt = 1'b1;
                        err_set = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_en_d   = 1'b1;
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                    end
                end
            end

            PAD: begin
                if (pix_fs) begin
                    err_set    = 1'b1;
                    state_d    = IN_FRAME;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                    fe_pend_d  = 1'b0;
                    skip_d     = 1'b0;
                end else begin
                    if (pix_fe) fe_pend_d = 1'b1;
                    if (pix_take) begin
                        err_set = 1'b1;
                        state_d = DROP;
                    end else if (fifo_full) begin
                        ovf_evt = 1'b1;
                        err_set = 1'b1;
                        state_d = DROP;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_byte_d = PAD_VALUE;
                        pix_cnt_d = pix_cnt_q + CNT_W'(1);
                        if (pad_last) begin
                            state_d    = IN_FRAME;
                            line_cnt_d = line_cnt_q + CNT_W'(1);
                            pix_cnt_d  = '0;
                        end
                    end
                end
            end

            DROP: begin
                if (pix_fs) begin
                    state_d    = IN_FRAME;
                    line_cnt_d = '0;
                    pix_cnt_d  = '0;
                    fe_pend_d  = 1'b0;
                    skip_d     = 1'b0;
                end
            end

            default: begin
                state_d = WAIT_FS;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= WAIT_FS;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            fe_pend_q    <= 1'b0;
            skip_q       <= 1'b0;
            fifo_wr_en   <= 1'b0;
            fifo_wr_data <= '0;
            frame_done   <= 1'b0;
            err_sticky   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_cnt_q  <= pix_cnt_d;
            line_cnt_q <= line_cnt_d;
            fe_pend_q  <= fe_pend_d;
            skip_q     <= skip_d;
            fifo_wr_en <= wr_en_d;
            if (wr_en_d) fifo_wr_data <= pack_word(wr_byte_d);
            frame_done <= done_d;
            // A fresh error outranks a clear arriving on the same edge.
            err_sticky <= err_set | (err_sticky & ~err_clr);
        end
    end

    sat_counter #(.W(16)) u_ovf_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ovf_evt),
        .clr   (1'b0),
        .count (ovf_cnt)
    );

    assign dbg_state = state_q;

endmodule
